// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment encoder/decoder pair.
//   - Segment bit positions within an 8-bit active-low bus (a..g, dp)
//   - SEG_BLANK: the all-off 7-segment pattern
//   - SEG_TABLE: active-low a..g pattern for each hex nibble 0..F
//   - scan_state_t: frame-assembly FSM states
//   - seg7_dec_t: decoded {err, blank, nibble} bundle
// No ports (package).
// ----------------------------------------------------------------------------
package seg7_pkg;

   // Bit positions on the 8-bit segment bus.
   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Entry [n] is the a..g pattern (active-low) that displays nibble n.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b0111000,   // F
      7'b0110000,   // E
      7'b1000010,   // D
      7'b0110001,   // C
      7'b1100000,   // B
      7'b0001000,   // A
      7'b0000100,   // 9
      7'b0000000,   // 8
      7'b0001111,   // 7
      7'b0100000,   // 6
      7'b0100100,   // 5
      7'b1001100,   // 4
      7'b0000110,   // 3
      7'b0010010,   // 2
      7'b1001111,   // 1
      7'b0000001    // 0
   };

   typedef enum logic {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } scan_state_t;

   typedef struct packed {
      logic       err;
      logic       blank;
      logic [3:0] nib;
   } seg7_dec_t;

   // Forward direction, used by the display driver side.
   function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
      return SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/seg7_pat_decode.sv
// ----------------------------------------------------------------------------
// seg7_pat_decode
// Combinational inverse of the hex-to-segment table.
// Ports:
//   i_pat  in  7  active-low a..g pattern ([6]=a ... [0]=g)
//   o_dec  out 6  {err, blank, nibble}; nibble is 0 when blank or err
// ----------------------------------------------------------------------------
module seg7_pat_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_pat,
   output seg7_dec_t  o_dec
);

   // NOTE: every field gets a default before the search so no path leaves
   // o_dec unassigned, which would otherwise infer a latch.
   always_comb begin
      o_dec = '0;
      if (i_pat == SEG_BLANK) begin
         o_dec.blank = 1'b1;
      end else begin
         o_dec.err = 1'b1;
         for (int k = 0; k < 16; k++) begin
            if (i_pat == SEG_TABLE[k]) begin
               o_dec.err = 1'b0;
               o_dec.nib = 4'(k);
            end
         end
      end
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// ----------------------------------------------------------------------------
// seg7_scan_decoder
// Samples a multiplexed active-low 7-segment bus, debounces each digit and
// assembles a full NDIG-digit frame of decoded nibbles behind valid/ready.
// Ports:
//   clk          in   1        rising-edge clock
//   rst_n        in   1        synchronous active-low reset
//   seg_in       in   8        active-low segments, [7]=a .. [1]=g, [0]=dp
//   an_in        in   NDIG     active-low one-hot digit select
//   sample_en    in   1        sample seg_in/an_in this cycle
//   frame_valid  out  1        frame snapshot available
//   frame_ready  in   1        consumer accepts frame
//   value        out  4*NDIG   decoded nibbles, digit i at [4i+3:4i]
//   dp_out       out  NDIG     decimal point per digit, active-high
//   blank        out  NDIG     digit pattern was all-off
//   err          out  NDIG     digit pattern not in the table
//   bad_scan     out  1        pulse: sampled an_in not exactly one low bit
// ----------------------------------------------------------------------------
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NDIG   = 8,
   parameter int STABLE = 3
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          seg_in,
   input  logic [NDIG-1:0]     an_in,
   input  logic                sample_en,
   output logic                frame_valid,
   input  logic                frame_ready,
   output logic [4*NDIG-1:0]   value,
   output logic [NDIG-1:0]     dp_out,
   output logic [NDIG-1:0]     blank,
   output logic [NDIG-1:0]     err,
   output logic                bad_scan
);

   localparam int CNTW = $clog2(STABLE + 1);
   localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CNTW-1:0] STABLE_C = CNTW'(STABLE);

   // Debounce state per digit.
   logic [7:0]        r_last [NDIG];
   logic [CNTW-1:0]   r_cnt  [NDIG];
   logic [NDIG-1:0]   r_seen;

   // Shadow frame, filled by commits.
   logic [4*NDIG-1:0] r_sh_val;
   logic [NDIG-1:0]   r_sh_dp;
   logic [NDIG-1:0]   r_sh_blank;
   logic [NDIG-1:0]   r_sh_err;

   // Presented frame.
   scan_state_t       r_state;
   logic              r_frame_valid;
   logic [4*NDIG-1:0] r_value;
   logic [NDIG-1:0]   r_dp;
   logic [NDIG-1:0]   r_blank;
   logic [NDIG-1:0]   r_err;
   logic              r_bad_scan;

   logic [NDIG-1:0]   w_an_act;
   logic              w_an_ok;
   logic [IDXW-1:0]   w_idx;
   logic [7:0]        w_last_sel;
   logic [CNTW-1:0]   w_cnt_sel;
   logic              w_same;
   logic              w_sat;
   logic [CNTW-1:0]   w_cnt_nxt;
   logic              w_valid_smp;
   logic              w_commit;
   logic [NDIG-1:0]   w_commit_vec;
   seg7_dec_t         w_dec;

   seg7_pat_decode u_decode (
      .i_pat (seg_in[7:1]),
      .o_dec (w_dec)
   );

   // Exactly one active digit: non-zero and clearing the lowest set bit
   // leaves nothing.
   assign w_an_act = ~an_in;
   assign w_an_ok  = (w_an_act != '0) &&
                     ((w_an_act & (w_an_act - NDIG'(1))) == '0);

   always_comb begin
      w_idx = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (w_an_act[i]) w_idx = IDXW'(i);
      end
   end

   assign w_last_sel  = r_last[w_idx];
   assign w_cnt_sel   = r_cnt[w_idx];
   assign w_same      = (seg_in == w_last_sel);
   assign w_sat       = (w_cnt_sel == STABLE_C);
   assign w_cnt_nxt   = !w_same ? CNTW'(1)
                      : (w_sat ? w_cnt_sel : w_cnt_sel + CNTW'(1));
   assign w_valid_smp = sample_en && w_an_ok;

   // Commit only on the transition into STABLE; a digit already saturated
   // on the same pattern stays quiet.
   assign w_commit     = w_valid_smp && (w_cnt_nxt == STABLE_C) && !(w_same && w_sat);
   assign w_commit_vec = w_commit ? w_an_act : '0;

   // NOTE: the shadow frame has no reset; it is only ever presented after
   // every digit has committed since reset, so stale contents cannot escape.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         r_sh_val[4*w_idx +: 4] <= w_dec.nib;
         r_sh_dp[w_idx]         <= ~seg_in[SEG_DP];
         r_sh_blank[w_idx]      <= w_dec.blank;
         r_sh_err[w_idx]        <= w_dec.err;
      end
   end

   // NOTE: all state here updates with non-blocking assignments so every
   // register sees the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= COLLECT;
         r_frame_valid <= 1'b0;
         r_value       <= '0;
         r_dp          <= '0;
         r_blank       <= '0;
         r_err         <= '0;
         r_bad_scan    <= 1'b0;
         r_seen        <= '0;
         for (int i = 0; i < NDIG; i++) begin
            r_last[i] <= 8'hFF;
            r_cnt[i]  <= '0;
         end
      end else begin
         r_bad_scan <= sample_en && !w_an_ok;

         if (w_valid_smp) begin
            r_last[w_idx] <= seg_in;
            r_cnt[w_idx]  <= w_cnt_nxt;
         end

         case (r_state)
            COLLECT: begin
               r_seen <= r_seen | w_commit_vec;
               if (&r_seen) begin
                  r_value       <= r_sh_val;
                  r_dp          <= r_sh_dp;
                  r_blank       <= r_sh_blank;
                  r_err         <= r_sh_err;
                  r_frame_valid <= 1'b1;
                  r_state       <= PRESENT;
               end
            end
            PRESENT: begin
               if (frame_ready) begin
                  // A commit landing with the handshake counts toward the
                  // next frame.
                  r_seen        <= w_commit_vec;
                  r_frame_valid <= 1'b0;
                  r_state       <= COLLECT;
               end else begin
                  r_seen <= r_seen | w_commit_vec;
               end
            end
            default: r_state <= COLLECT;
         endcase
      end
   end

   assign frame_valid = r_frame_valid;
   assign value       = r_value;
   assign dp_out      = r_dp;
   assign blank       = r_blank;
   assign err         = r_err;
   assign bad_scan    = r_bad_scan;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Self-checking bench: a per-digit behavioural model (integer counters,
// arrays, a table lookup) is compared against the DUT on every falling edge;
// directed scenarios add literal expectations, then a randomized phase runs.
// ----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

   localparam int NDIG   = 8;
   localparam int STABLE = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [7:0]        seg_in;
   logic [NDIG-1:0]   an_in;
   logic              sample_en;
   logic              frame_valid;
   logic              frame_ready;
   logic [4*NDIG-1:0] value;
   logic [NDIG-1:0]   dp_out;
   logic [NDIG-1:0]   blank;
   logic [NDIG-1:0]   err;
   logic              bad_scan;

   int n_checks = 0;
   int n_errors = 0;

   seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .an_in       (an_in),
      .sample_en   (sample_en),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .value       (value),
      .dp_out      (dp_out),
      .blank       (blank),
      .err         (err),
      .bad_scan    (bad_scan)
   );

   always #5 clk = ~clk;

   // Hex digit patterns, a..g active-low.
   logic [6:0] tb_pat [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pat(input int v);
      return {tb_pat[v], 1'b1};
   endfunction

   // ---------------- behavioural model ----------------
   logic [7:0] m_last    [NDIG];
   int         m_cnt     [NDIG];
   bit         m_seen    [NDIG];
   logic [3:0] m_sh_nib  [NDIG];
   bit         m_sh_dp   [NDIG];
   bit         m_sh_bl   [NDIG];
   bit         m_sh_er   [NDIG];
   logic [3:0] m_out_nib [NDIG];
   bit         m_out_dp  [NDIG];
   bit         m_out_bl  [NDIG];
   bit         m_out_er  [NDIG];
   bit         m_valid;
   bit         m_bad;

   function automatic void ref_decode(input logic [6:0] p, output logic [3:0] nib,
                                      output bit bl, output bit er);
      nib = 4'h0;
      bl  = 1'b0;
      er  = 1'b1;
      if (p == 7'b1111111) begin
         bl = 1'b1;
         er = 1'b0;
      end else begin
         for (int k = 0; k < 16; k++) begin
            if (p == tb_pat[k]) begin
               nib = 4'(k);
               er  = 1'b0;
            end
         end
      end
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_bad   = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         m_last[i]    = 8'hFF;
         m_cnt[i]     = 0;
         m_seen[i]    = 1'b0;
         m_out_nib[i] = 4'h0;
         m_out_dp[i]  = 1'b0;
         m_out_bl[i]  = 1'b0;
         m_out_er[i]  = 1'b0;
      end
   endtask

   // Advances the model by one rising edge using the inputs now applied.
   task automatic model_step();
      int d;
      int lows;
      bit commit;
      bit all_seen;
      logic [3:0] nib;
      bit bl;
      bit er;
      if (!rst_n) begin
         model_reset();
         return;
      end
      d      = 0;
      commit = 1'b0;
      m_bad  = 1'b0;
      if (sample_en) begin
         lows = 0;
         for (int i = 0; i < NDIG; i++) begin
            if (!an_in[i]) begin
               lows++;
               d = i;
            end
         end
         if (lows != 1) begin
            m_bad = 1'b1;
         end else if (seg_in == m_last[d]) begin
            if (m_cnt[d] < STABLE) begin
               m_cnt[d]++;
               commit = (m_cnt[d] == STABLE);
            end
         end else begin
            m_last[d] = seg_in;
            m_cnt[d]  = 1;
            commit    = (STABLE == 1);
         end
      end
      all_seen = 1'b1;
      for (int i = 0; i < NDIG; i++) all_seen &= m_seen[i];
      if (!m_valid) begin
         if (all_seen) begin
            for (int i = 0; i < NDIG; i++) begin
               m_out_nib[i] = m_sh_nib[i];
               m_out_dp[i]  = m_sh_dp[i];
               m_out_bl[i]  = m_sh_bl[i];
               m_out_er[i]  = m_sh_er[i];
            end
            m_valid = 1'b1;
         end
      end else if (frame_ready) begin
         for (int i = 0; i < NDIG; i++) m_seen[i] = 1'b0;
         m_valid = 1'b0;
      end
      if (commit) begin
         ref_decode(seg_in[7:1], nib, bl, er);
         m_sh_nib[d] = nib;
         m_sh_dp[d]  = !seg_in[0];
         m_sh_bl[d]  = bl;
         m_sh_er[d]  = er;
         m_seen[d]   = 1'b1;
      end
   endtask

   function automatic logic [4*NDIG-1:0] m_value();
      logic [4*NDIG-1:0] v = '0;
      for (int i = 0; i < NDIG; i++) v[4*i +: 4] = m_out_nib[i];
      return v;
   endfunction

   function automatic logic [NDIG-1:0] m_vec(input int which);
      logic [NDIG-1:0] v = '0;
      for (int i = 0; i < NDIG; i++) begin
         case (which)
            0:       v[i] = m_out_dp[i];
            1:       v[i] = m_out_bl[i];
            default: v[i] = m_out_er[i];
         endcase
      end
      return v;
   endfunction

   // Compare on the falling edge, then step the model with the inputs that
   // the next rising edge will sample (stimulus changes only after rising
   // edges).
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         check("m_frame_valid", frame_valid, m_valid);
         check("m_value",       value,       m_value());
         check("m_dp_out",      dp_out,      m_vec(0));
         check("m_blank",       blank,       m_vec(1));
         check("m_err",         err,         m_vec(2));
         check("m_bad_scan",    bad_scan,    m_bad);
         model_step();
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] scan_pat [NDIG];
   int         rd;
   int         rr;
   int         reps;
   logic [7:0] rs;
   logic [7:0] ran;

   task automatic cyc(input logic en, input logic [7:0] an, input logic [7:0] seg);
      sample_en = en;
      an_in     = an;
      seg_in    = seg;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'hFF, 8'hFF);
   endtask

   task automatic samp(input int d, input logic [7:0] s);
      if ($urandom_range(0, 3) == 0) idle(1);
      cyc(1'b1, ~(8'(1) << d), s);
   endtask

   task automatic scan_rounds(input int rounds, input logic [7:0] mask);
      for (int r = 0; r < rounds; r++)
         for (int d = 0; d < NDIG; d++)
            if (mask[d]) samp(d, scan_pat[d]);
   endtask

   task automatic handshake();
      frame_ready = 1'b1;
      idle(1);
      frame_ready = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      frame_ready = 1'b0;
      sample_en   = 1'b0;
      an_in       = 8'hFF;
      seg_in      = 8'hFF;
      idle(2);
      rst_n = 1'b1;
      check("reset_valid", frame_valid, 1'b0);
      check("reset_value", value, 32'h0);

      // Digits 0..7 show 1..8.
      for (int d = 0; d < NDIG; d++) scan_pat[d] = pat(d + 1);
      scan_rounds(STABLE, 8'hFF);
      idle(2);
      check("frame1_valid", frame_valid, 1'b1);
      check("frame1_value", value, 32'h87654321);
      check("frame1_err",   err,   8'h00);
      check("frame1_blank", blank, 8'h00);
      handshake();
      check("hs1_valid", frame_valid, 1'b0);

      // Digit 2 flips 2/3 on every sample and never settles.
      for (int d = 0; d < NDIG; d++) scan_pat[d] = pat((d + 9) % 16);
      for (int r = 0; r < STABLE; r++)
         for (int d = 0; d < NDIG; d++)
            samp(d, (d == 2) ? pat((r % 2 == 0) ? 2 : 3) : scan_pat[d]);
      idle(2);
      check("flip_no_frame", frame_valid, 1'b0);
      for (int r = 0; r < STABLE; r++) samp(2, pat(3));
      idle(2);
      check("flip_valid", frame_valid, 1'b1);
      check("flip_digit2", value[11:8], 4'h3);
      check("flip_value", value, 32'h0FEDC3A9);

      // Back-pressure: commits during PRESENT stay in the shadow.
      cyc(1'b1, ~8'h01, pat(10));
      cyc(1'b1, ~8'h01, pat(10));
      for (int r = 0; r < STABLE; r++) cyc(1'b1, ~8'h02, pat(5));
      idle(20 - 2 - STABLE);
      check("hold_valid", frame_valid, 1'b1);
      check("hold_value", value, 32'h0FEDC3A9);
      // Third A sample commits together with the handshake.
      frame_ready = 1'b1;
      cyc(1'b1, ~8'h01, pat(10));
      frame_ready = 1'b0;
      check("hs2_valid", frame_valid, 1'b0);
      for (int d = 1; d < NDIG; d++) scan_pat[d] = pat(d);
      scan_rounds(STABLE, 8'hFE);
      idle(2);
      check("frame3_valid", frame_valid, 1'b1);
      check("frame3_digit0", value[3:0], 4'hA);
      check("frame3_value", value, 32'h7654321A);
      handshake();

      // Blank with decimal point on digit 5.
      for (int d = 0; d < NDIG; d++) scan_pat[d] = (d == 5) ? 8'hFE : pat(8);
      scan_rounds(STABLE, 8'hFF);
      idle(2);
      check("blank_valid", frame_valid, 1'b1);
      check("blank_vec",   blank,  8'h20);
      check("blank_dp",    dp_out, 8'h20);
      check("blank_value", value,  32'h88088888);
      handshake();

      // Undecodable pattern on digit 5.
      for (int d = 0; d < NDIG; d++) scan_pat[d] = (d == 5) ? {7'b1010101, 1'b1} : pat(9);
      scan_rounds(STABLE, 8'hFF);
      idle(2);
      check("err_vec",   err,   8'h20);
      check("err_blank", blank, 8'h00);
      check("err_value", value, 32'h99099999);
      handshake();

      // Malformed anode selects.
      cyc(1'b1, 8'hFF, pat(4));
      check("bad_ff", bad_scan, 1'b1);
      idle(1);
      check("bad_clear", bad_scan, 1'b0);
      cyc(1'b1, 8'hFC, pat(4));
      check("bad_fc", bad_scan, 1'b1);
      idle(1);

      // Randomized traffic against the model.
      for (int n = 0; n < 500; n++) begin
         rd = $urandom_range(0, NDIG - 1);
         rr = $urandom_range(0, 9);
         if (rr < 6)      rs = {tb_pat[$urandom_range(0, 3)], 1'($urandom_range(0, 1))};
         else if (rr < 8) rs = {7'b1111111, 1'($urandom_range(0, 1))};
         else             rs = 8'($urandom);
         reps = $urandom_range(1, 4);
         for (int k = 0; k < reps; k++) begin
            frame_ready = ($urandom_range(0, 3) == 0);
            ran = ($urandom_range(0, 15) == 0) ? 8'($urandom) : ~(8'(1) << rd);
            cyc($urandom_range(0, 4) != 0, ran, rs);
         end
      end
      frame_ready = 1'b0;

      // Reset while a frame is presented.
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      for (int d = 0; d < NDIG; d++) scan_pat[d] = pat(15 - d);
      scan_rounds(STABLE, 8'hFF);
      idle(2);
      check("pre_rst_valid", frame_valid, 1'b1);
      check("pre_rst_value", value, 32'h89ABCDEF);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      check("rst_valid", frame_valid, 1'b0);
      check("rst_value", value,  32'h0);
      check("rst_dp",    dp_out, 8'h00);
      check("rst_blank", blank,  8'h00);
      check("rst_err",   err,    8'h00);
      scan_rounds(STABLE, 8'h7F);
      idle(2);
      check("rst_partial", frame_valid, 1'b0);
      scan_rounds(STABLE, 8'h80);
      idle(2);
      check("rst_refill_valid", frame_valid, 1'b1);
      check("rst_refill_value", value, 32'h89ABCDEF);

      idle(2);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Inverse of the hex-to-segment encoder. Samples a multiplexed, active-low 7-segment display bus (segment pattern plus digit anode select), debounces each digit, and decodes the patterns back to hex nibbles. It presents a complete NDIG-digit frame through a valid/ready handshake. It sits between a display-scan tap (or a loopback of our own display driver) and self-check or readback logic.

Parameters:
NDIG, 8, number of multiplexed digits; anode bus width
STABLE, 3, consecutive identical samples of a digit required before commit (1..15)

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  synchronous active-low reset
seg_in  input  8  active-low segments; [7]=a [6]=b [5]=c [4]=d [3]=e [2]=f [1]=g [0]=dp
an_in  input  NDIG  active-low one-hot digit select; bit i low = digit i driven
sample_en  input  1  strobe: sample seg_in/an_in this cycle
frame_valid  output  1  frame snapshot available
frame_ready  input  1  consumer accepts frame
value  output  4*NDIG  decoded nibbles; digit i at [4i+3:4i]
dp_out  output  NDIG  decimal point per digit, active-high
blank  output  NDIG  digit pattern was all-off (1111111)
err  output  NDIG  digit pattern not in decode table
bad_scan  output  1  one-cycle pulse: sampled an_in not exactly one low bit

Behaviour:
- Interface fixed: one clock, clk; reset rst_n synchronous, active-low.
- Decode table, seg_in[7:1] -> nibble:
  0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=B, 0110001=C, 1000010=D, 0110000=E, 0111000=F.
  1111111 -> blank=1, nibble 0. Any other pattern -> err=1, nibble 0.
- Sample (sample_en=1):
  - an_in not exactly one low bit -> sample ignored, bad_scan=1 next cycle.
  - Otherwise digit i = index of the low bit.
- Per-digit state: last raw 8-bit pattern and a saturating count 0..STABLE.
  - Raw pattern == last -> count increments, saturating at STABLE.
  - Raw pattern differs -> store it, count=1.
- Commit: occurs on the sample where count becomes STABLE; STABLE=1 commits on the first sample.
  - Writes decoded nibble, dp, blank and err into the shadow registers for digit i.
  - Sets seen[i].
  - Samples after saturation do not re-commit.
- FSM, two states:
  - COLLECT: when all seen bits are set, copy shadow to the output registers and go to PRESENT with frame_valid=1 next cycle.
  - PRESENT: outputs held stable while frame_ready=0; commits continue into shadow only. frame_valid&frame_ready -> clear all seen bits, back to COLLECT, frame_valid=0 next cycle.
- Simultaneous handshake and commit of digit i: seen cleared except seen[i]=1 (commit wins).
- Reset (any cycle, including mid-frame or in PRESENT): state=COLLECT, frame_valid=0, value/dp_out/blank/err/bad_scan=0, all counts=0, seen=0, last patterns=8'hFF.
- Latency: first frame_valid 1 cycle after the commit that completes the seen set.
- Width rules: count width is $clog2(STABLE+1); digit index width is $clog2(NDIG), minimum 1.

Decomposition:
- Shared package seg7_pkg:
  - segment bit-position constants
  - SEG_BLANK=7'b1111111
  - 16-entry pattern table constant
  - FSM state enum {COLLECT, PRESENT}
  - The encoder and this block both consume the table.
- Sub-module seg7_pat_decode: combinational 7-bit pattern -> {err, blank, nibble}, instantiated once on seg_in.

Test Plan:
- Reset, then NDIG=8, STABLE=3: scan digits 0..7 with patterns for 1,2,3,4,5,6,7,8, each digit sampled 3 times in round-robin -> frame_valid=1, value=32'h87654321, err=0, blank=0.
- Digit 2 alternates 0010010/0000110 every sample -> never commits, frame_valid stays 0; then hold 0000110 for 3 samples -> commit, value[11:8]=3.
- frame_ready=0 for 20 cycles while digit 0 changes to A and commits -> outputs unchanged; ready=1 -> handshake; next frame value[3:0]=A once all digits re-committed.
- Digit 5 pattern 1111111 with dp low (seg_in=8'hFE) -> blank[5]=1, dp_out[5]=1, value[23:20]=0. Pattern 1010101 -> err[5]=1.
- an_in=8'hFF and an_in=8'hFC with sample_en -> bad_scan pulse each, no count change.
- rst_n=0 one cycle while in PRESENT -> frame_valid=0 and all outputs 0 next cycle; a full new scan is required before the next frame.
